// File: rtl/core_pkg.sv
// Shared core definitions: ALU operation encoding, ID/EX aluop encoding,
// R-type function codes and the default register index width.
package core_pkg;

  localparam int REG_AW_DEF = 5;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_SLT = 3'd4
  } op_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ORI   = 2'b11
  } aluop_t;

  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  // Logical immediates are zero-extended, everything else sign-extended.
  function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic zext);
    return zext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX input bundle, forwarding taps and EX/MEM output bundle of the
// execute stage. master = surrounding pipeline, slave = ex_stage.
interface ex_stage_if #(parameter int REG_AW = core_pkg::REG_AW_DEF);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] in_rs;
  logic [REG_AW-1:0] in_rt;
  logic [REG_AW-1:0] in_rd;
  logic [31:0]       in_rs_val;
  logic [31:0]       in_rt_val;
  logic [15:0]       in_imm;
  logic              in_alu_src;
  logic [1:0]        in_aluop;
  logic [5:0]        in_funct;
  logic              in_reg_write;
  logic              in_mem_read;
  logic              in_mem_write;
  logic              fwd_em_we;
  logic [REG_AW-1:0] fwd_em_rd;
  logic [31:0]       fwd_em_val;
  logic              fwd_mw_we;
  logic [REG_AW-1:0] fwd_mw_rd;
  logic [31:0]       fwd_mw_val;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_result;
  logic [31:0]       out_store_data;
  logic [REG_AW-1:0] out_rd;
  logic              out_reg_write;
  logic              out_mem_read;
  logic              out_mem_write;
  logic              out_zero;
  logic              out_ovf_trap;
  logic              out_illegal;

  modport master (
    output flush, in_valid, in_rs, in_rt, in_rd, in_rs_val, in_rt_val, in_imm,
           in_alu_src, in_aluop, in_funct, in_reg_write, in_mem_read, in_mem_write,
           fwd_em_we, fwd_em_rd, fwd_em_val, fwd_mw_we, fwd_mw_rd, fwd_mw_val,
           out_ready,
    input  in_ready, out_valid, out_result, out_store_data, out_rd, out_reg_write,
           out_mem_read, out_mem_write, out_zero, out_ovf_trap, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_rs, in_rt, in_rd, in_rs_val, in_rt_val, in_imm,
           in_alu_src, in_aluop, in_funct, in_reg_write, in_mem_read, in_mem_write,
           fwd_em_we, fwd_em_rd, fwd_em_val, fwd_mw_we, fwd_mw_rd, fwd_mw_val,
           out_ready,
    output in_ready, out_valid, out_result, out_store_data, out_rd, out_reg_write,
           out_mem_read, out_mem_write, out_zero, out_ovf_trap, out_illegal
  );
endinterface

// File: rtl/alu.sv
// 32-bit ALU: AND/OR/ADD/SUB/signed SLT with zero and signed-overflow flags.
module alu
  import core_pkg::*;
(
  input  op_t         op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow
);

  logic [31:0] sum;
  logic [31:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  // Operation select; overflow only meaningful for ADD/SUB.
  always_comb begin
    result   = 32'h0;
    overflow = 1'b0;
    case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_ADD: begin
        result   = sum;
        overflow = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      OP_SUB: begin
        result   = diff;
        overflow = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      OP_SLT: result = {31'h0, ($signed(a) < $signed(b))};
      default: result = 32'h0;
    endcase
  end

  assign zero = (result == 32'h0);

endmodule

// File: rtl/alu_control.sv
// Maps aluop/funct to an ALU op plus trapping and illegal-instruction flags.
module alu_control
  import core_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output op_t        op,
  output logic       trapping,
  output logic       illegal
);

  // Decode; unknown R-type funct falls back to AND and flags illegal.
  always_comb begin
    op       = OP_ADD;
    trapping = 1'b0;
    illegal  = 1'b0;
    case (aluop)
      ALUOP_ADD: op = OP_ADD;
      ALUOP_SUB: op = OP_SUB;
      ALUOP_ORI: op = OP_OR;
      default: begin
        case (funct)
          FUNCT_ADD:  begin op = OP_ADD; trapping = 1'b1; end
          FUNCT_ADDU: op = OP_ADD;
          FUNCT_SUB:  begin op = OP_SUB; trapping = 1'b1; end
          FUNCT_SUBU: op = OP_SUB;
          FUNCT_AND:  op = OP_AND;
          FUNCT_OR:   op = OP_OR;
          FUNCT_SLT:  op = OP_SLT;
          default: begin
            op      = OP_AND;
            illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU control decode, ALU, and the
// EX/MEM output register behind a valid/ready handshake with flush.
module ex_stage
  import core_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEF,
  parameter bit TRAP_EN = 1'b1
) (
  input logic  clk,
  input logic  rst,
  ex_stage_if.slave bus
);

  logic [REG_AW-1:0] rs_idx;
  logic [REG_AW-1:0] rt_idx;
  logic [31:0]       rs_fwd;
  logic [31:0]       rt_fwd;
  logic [31:0]       imm_ext;
  logic [31:0]       alu_b;
  op_t               alu_op;
  logic              op_trapping;
  logic              op_illegal;
  logic [31:0]       alu_result;
  logic              alu_zero;
  logic              alu_ovf;
  logic              trap;

  assign rs_idx = bus.in_rs;
  assign rt_idx = bus.in_rt;

  // Youngest producer wins; r0 is hard zero and never forwarded.
  function automatic logic [31:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic [31:0]       rf_val,
    input logic              em_we,
    input logic [REG_AW-1:0] em_rd,
    input logic [31:0]       em_val,
    input logic              mw_we,
    input logic [REG_AW-1:0] mw_rd,
    input logic [31:0]       mw_val
  );
    if (src != '0 && em_we && em_rd == src)      return em_val;
    else if (src != '0 && mw_we && mw_rd == src) return mw_val;
    else                                         return rf_val;
  endfunction

  // Operand forwarding and ALU b-operand selection.
  always_comb begin
    rs_fwd  = fwd_sel(rs_idx, bus.in_rs_val, bus.fwd_em_we, bus.fwd_em_rd, bus.fwd_em_val,
                      bus.fwd_mw_we, bus.fwd_mw_rd, bus.fwd_mw_val);
    rt_fwd  = fwd_sel(rt_idx, bus.in_rt_val, bus.fwd_em_we, bus.fwd_em_rd, bus.fwd_em_val,
                      bus.fwd_mw_we, bus.fwd_mw_rd, bus.fwd_mw_val);
    imm_ext = ext_imm(bus.in_imm, bus.in_aluop == ALUOP_ORI);
    alu_b   = bus.in_alu_src ? imm_ext : rt_fwd;
  end

  alu_control u_alu_control (
    .aluop    (bus.in_aluop),
    .funct    (bus.in_funct),
    .op       (alu_op),
    .trapping (op_trapping),
    .illegal  (op_illegal)
  );

  alu u_alu (
    .op       (alu_op),
    .a        (rs_fwd),
    .b        (alu_b),
    .result   (alu_result),
    .zero     (alu_zero),
    .overflow (alu_ovf)
  );

  assign trap         = TRAP_EN && op_trapping && alu_ovf;
  assign bus.in_ready = !bus.out_valid || bus.out_ready;

  // EX/MEM register: reset > flush > capture; holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid      <= 1'b0;
      bus.out_result     <= 32'h0;
      bus.out_store_data <= 32'h0;
      bus.out_rd         <= '0;
      bus.out_reg_write  <= 1'b0;
      bus.out_mem_read   <= 1'b0;
      bus.out_mem_write  <= 1'b0;
      bus.out_zero       <= 1'b0;
      bus.out_ovf_trap   <= 1'b0;
      bus.out_illegal    <= 1'b0;
    end else if (bus.flush) begin
      bus.out_valid      <= 1'b0;
      bus.out_reg_write  <= 1'b0;
      bus.out_mem_read   <= 1'b0;
      bus.out_mem_write  <= 1'b0;
      bus.out_ovf_trap   <= 1'b0;
      bus.out_illegal    <= 1'b0;
    end else if (bus.in_ready) begin
      bus.out_valid      <= bus.in_valid;
      bus.out_result     <= alu_result;
      bus.out_store_data <= rt_fwd;
      bus.out_rd         <= bus.in_rd;
      bus.out_zero       <= alu_zero;
      bus.out_reg_write  <= bus.in_valid && bus.in_reg_write && !op_illegal && !trap;
      bus.out_mem_read   <= bus.in_valid && bus.in_mem_read;
      bus.out_mem_write  <= bus.in_valid && bus.in_mem_write;
      bus.out_ovf_trap   <= bus.in_valid && trap;
      bus.out_illegal    <= bus.in_valid && op_illegal;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: one task per scenario, inline checks.
module tb_ex_stage;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  ex_stage_if #(.REG_AW(5)) bus ();

  ex_stage #(.REG_AW(5), .TRAP_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    bus.fwd_em_we = 1'b0; bus.fwd_em_rd = '0; bus.fwd_em_val = '0;
    bus.fwd_mw_we = 1'b0; bus.fwd_mw_rd = '0; bus.fwd_mw_val = '0;
  endtask

  task automatic set_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] rs_val, input logic [31:0] rt_val,
                           input logic [5:0] funct);
    bus.in_valid = 1'b1; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
    bus.in_rs_val = rs_val; bus.in_rt_val = rt_val; bus.in_imm = 16'h0;
    bus.in_alu_src = 1'b0; bus.in_aluop = 2'b10; bus.in_funct = funct;
    bus.in_reg_write = 1'b1; bus.in_mem_read = 1'b0; bus.in_mem_write = 1'b0;
  endtask

  task automatic set_itype(input logic [1:0] aluop, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [31:0] rs_val,
                           input logic [31:0] rt_val, input logic [15:0] imm,
                           input logic mem_read);
    bus.in_valid = 1'b1; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
    bus.in_rs_val = rs_val; bus.in_rt_val = rt_val; bus.in_imm = imm;
    bus.in_alu_src = 1'b1; bus.in_aluop = aluop; bus.in_funct = 6'h0;
    bus.in_reg_write = 1'b1; bus.in_mem_read = mem_read; bus.in_mem_write = 1'b0;
  endtask

  task automatic test_reset();
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    set_rtype(5'd1, 5'd2, 5'd3, 32'd1, 32'd2, FUNCT_ADDU);
    clear_fwd();
    rst = 1'b1;
    step(); step();
    total_cnt++;
    if ({bus.out_valid, bus.out_result, bus.out_store_data, bus.out_rd, bus.out_reg_write,
         bus.out_mem_read, bus.out_mem_write, bus.out_zero, bus.out_ovf_trap,
         bus.out_illegal} !== 76'd0)
      $display("FAIL reset_outputs got valid=%b result=%h store=%h rd=%0d rw=%b exp all 0",
               bus.out_valid, bus.out_result, bus.out_store_data, bus.out_rd, bus.out_reg_write);
    else pass_cnt++;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", bus.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_alu_ops();
    set_rtype(5'd1, 5'd2, 5'd9, 32'd5, 32'd7, FUNCT_ADDU);
    step();
    total_cnt++;
    if ({bus.out_valid, bus.out_result, bus.out_zero, bus.out_reg_write, bus.out_rd} !==
        {1'b1, 32'd12, 1'b0, 1'b1, 5'd9})
      $display("FAIL alu_add got v=%b r=%h z=%b rw=%b rd=%0d exp v=1 r=0000000c z=0 rw=1 rd=9",
               bus.out_valid, bus.out_result, bus.out_zero, bus.out_reg_write, bus.out_rd);
    else pass_cnt++;

    set_rtype(5'd1, 5'd2, 5'd9, 32'd5, 32'd5, FUNCT_SUBU);
    step();
    total_cnt++;
    if ({bus.out_result, bus.out_zero} !== {32'd0, 1'b1})
      $display("FAIL alu_sub_zero got r=%h z=%b exp r=0 z=1", bus.out_result, bus.out_zero);
    else pass_cnt++;

    set_rtype(5'd1, 5'd2, 5'd9, 32'h000000F0, 32'h0000003C, FUNCT_AND);
    step();
    total_cnt++;
    if (bus.out_result !== 32'h30)
      $display("FAIL alu_and got %h exp 00000030", bus.out_result);
    else pass_cnt++;

    set_rtype(5'd1, 5'd2, 5'd9, 32'h000000F0, 32'h0000003C, FUNCT_OR);
    step();
    total_cnt++;
    if (bus.out_result !== 32'hFC)
      $display("FAIL alu_or got %h exp 000000fc", bus.out_result);
    else pass_cnt++;

    set_rtype(5'd1, 5'd2, 5'd9, 32'hFFFFFFFF, 32'd1, FUNCT_SLT);
    step();
    total_cnt++;
    if (bus.out_result !== 32'd1)
      $display("FAIL alu_slt_signed got %h exp 00000001", bus.out_result);
    else pass_cnt++;

    set_rtype(5'd1, 5'd2, 5'd9, 32'd1, 32'hFFFFFFFF, FUNCT_SLT);
    step();
    total_cnt++;
    if ({bus.out_result, bus.out_zero} !== {32'd0, 1'b1})
      $display("FAIL alu_slt_false got r=%h z=%b exp r=0 z=1", bus.out_result, bus.out_zero);
    else pass_cnt++;
  endtask

  task automatic test_forwarding();
    set_rtype(5'd3, 5'd4, 5'd8, 32'd77, 32'd1, FUNCT_SUB);
    bus.fwd_em_we = 1'b1; bus.fwd_em_rd = 5'd3; bus.fwd_em_val = 32'd100;
    bus.fwd_mw_we = 1'b1; bus.fwd_mw_rd = 5'd3; bus.fwd_mw_val = 32'd200;
    step();
    total_cnt++;
    if (bus.out_result !== 32'd99)
      $display("FAIL fwd_em_priority got %0d exp 99", bus.out_result);
    else pass_cnt++;

    set_rtype(5'd0, 5'd4, 5'd8, 32'd0, 32'd1, FUNCT_SUB);
    bus.fwd_em_rd = 5'd0; bus.fwd_mw_rd = 5'd0;
    step();
    total_cnt++;
    if (bus.out_result !== 32'hFFFFFFFF)
      $display("FAIL fwd_r0_never got %h exp ffffffff", bus.out_result);
    else pass_cnt++;

    set_rtype(5'd7, 5'd4, 5'd8, 32'd30, 32'd999, FUNCT_SUBU);
    bus.fwd_em_we = 1'b0; bus.fwd_em_rd = 5'd4; bus.fwd_em_val = 32'd555;
    bus.fwd_mw_we = 1'b1; bus.fwd_mw_rd = 5'd4; bus.fwd_mw_val = 32'd10;
    step();
    total_cnt++;
    if ({bus.out_result, bus.out_store_data} !== {32'd20, 32'd10})
      $display("FAIL fwd_mw_rt got r=%0d sd=%0d exp r=20 sd=10", bus.out_result, bus.out_store_data);
    else pass_cnt++;
    clear_fwd();
  endtask

  task automatic test_overflow();
    set_rtype(5'd1, 5'd2, 5'd5, 32'h7FFFFFFF, 32'd1, FUNCT_ADD);
    step();
    total_cnt++;
    if ({bus.out_result, bus.out_ovf_trap, bus.out_reg_write} !== {32'h80000000, 1'b1, 1'b0})
      $display("FAIL ovf_add_trap got r=%h t=%b rw=%b exp r=80000000 t=1 rw=0",
               bus.out_result, bus.out_ovf_trap, bus.out_reg_write);
    else pass_cnt++;

    set_rtype(5'd1, 5'd2, 5'd5, 32'h7FFFFFFF, 32'd1, FUNCT_ADDU);
    step();
    total_cnt++;
    if ({bus.out_result, bus.out_ovf_trap, bus.out_reg_write} !== {32'h80000000, 1'b0, 1'b1})
      $display("FAIL ovf_addu_notrap got r=%h t=%b rw=%b exp r=80000000 t=0 rw=1",
               bus.out_result, bus.out_ovf_trap, bus.out_reg_write);
    else pass_cnt++;

    set_rtype(5'd1, 5'd2, 5'd5, 32'h80000000, 32'd1, FUNCT_SUB);
    step();
    total_cnt++;
    if ({bus.out_result, bus.out_ovf_trap, bus.out_reg_write} !== {32'h7FFFFFFF, 1'b1, 1'b0})
      $display("FAIL ovf_sub_trap got r=%h t=%b rw=%b exp r=7fffffff t=1 rw=0",
               bus.out_result, bus.out_ovf_trap, bus.out_reg_write);
    else pass_cnt++;
  endtask

  task automatic test_immediate();
    set_itype(2'b11, 5'd1, 5'd0, 5'd6, 32'd0, 32'd0, 16'h8001, 1'b0);
    step();
    total_cnt++;
    if (bus.out_result !== 32'h00008001)
      $display("FAIL imm_ori_zext got %h exp 00008001", bus.out_result);
    else pass_cnt++;

    set_itype(2'b00, 5'd1, 5'd6, 5'd7, 32'd16, 32'd3, 16'hFFFC, 1'b1);
    bus.fwd_em_we = 1'b1; bus.fwd_em_rd = 5'd6; bus.fwd_em_val = 32'h0000ABCD;
    step();
    total_cnt++;
    if ({bus.out_result, bus.out_store_data, bus.out_mem_read} !== {32'd12, 32'h0000ABCD, 1'b1})
      $display("FAIL imm_add_sext got r=%h sd=%h mr=%b exp r=0000000c sd=0000abcd mr=1",
               bus.out_result, bus.out_store_data, bus.out_mem_read);
    else pass_cnt++;
    clear_fwd();

    set_itype(2'b01, 5'd1, 5'd0, 5'd7, 32'd10, 32'd0, 16'd3, 1'b0);
    step();
    total_cnt++;
    if (bus.out_result !== 32'd7)
      $display("FAIL imm_sub got %0d exp 7", bus.out_result);
    else pass_cnt++;
  endtask

  task automatic test_illegal();
    set_rtype(5'd1, 5'd2, 5'd5, 32'h000000F0, 32'h0000003C, 6'h3F);
    step();
    total_cnt++;
    if ({bus.out_valid, bus.out_illegal, bus.out_reg_write, bus.out_result} !==
        {1'b1, 1'b1, 1'b0, 32'h30})
      $display("FAIL illegal_funct got v=%b il=%b rw=%b r=%h exp v=1 il=1 rw=0 r=00000030",
               bus.out_valid, bus.out_illegal, bus.out_reg_write, bus.out_result);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    set_rtype(5'd1, 5'd2, 5'd10, 32'd2, 32'd3, FUNCT_ADDU);
    step();
    total_cnt++;
    if ({bus.out_valid, bus.out_result, bus.out_rd} !== {1'b1, 32'd5, 5'd10})
      $display("FAIL b2b_first got v=%b r=%0d rd=%0d exp v=1 r=5 rd=10",
               bus.out_valid, bus.out_result, bus.out_rd);
    else pass_cnt++;
    set_rtype(5'd1, 5'd2, 5'd11, 32'd40, 32'd2, FUNCT_SUBU);
    step();
    total_cnt++;
    if ({bus.out_valid, bus.out_result, bus.out_rd} !== {1'b1, 32'd38, 5'd11})
      $display("FAIL b2b_second got v=%b r=%0d rd=%0d exp v=1 r=38 rd=11",
               bus.out_valid, bus.out_result, bus.out_rd);
    else pass_cnt++;
    bus.in_valid = 1'b0;
    step();
    total_cnt++;
    if ({bus.out_valid, bus.out_reg_write} !== 2'b00)
      $display("FAIL bubble got v=%b rw=%b exp v=0 rw=0", bus.out_valid, bus.out_reg_write);
    else pass_cnt++;
  endtask

  task automatic test_stall_flush();
    bus.out_ready = 1'b0;
    set_rtype(5'd1, 5'd2, 5'd5, 32'd10, 32'd3, FUNCT_SUBU);
    step();
    total_cnt++;
    if ({bus.out_valid, bus.out_result, bus.in_ready} !== {1'b1, 32'd7, 1'b0})
      $display("FAIL stall_capture got v=%b r=%0d ir=%b exp v=1 r=7 ir=0",
               bus.out_valid, bus.out_result, bus.in_ready);
    else pass_cnt++;
    set_rtype(5'd1, 5'd2, 5'd6, 32'd100, 32'd1, FUNCT_ADDU);
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if ({bus.out_valid, bus.out_result, bus.out_rd, bus.out_reg_write, bus.in_ready} !==
          {1'b1, 32'd7, 5'd5, 1'b1, 1'b0})
        $display("FAIL stall_hold_%0d got v=%b r=%0d rd=%0d rw=%b ir=%b exp v=1 r=7 rd=5 rw=1 ir=0",
                 i, bus.out_valid, bus.out_result, bus.out_rd, bus.out_reg_write, bus.in_ready);
      else pass_cnt++;
    end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    total_cnt++;
    if ({bus.out_valid, bus.out_reg_write, bus.in_ready} !== 3'b001)
      $display("FAIL flush got v=%b rw=%b ir=%b exp v=0 rw=0 ir=1",
               bus.out_valid, bus.out_reg_write, bus.in_ready);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({bus.out_valid, bus.out_result, bus.out_rd} !== {1'b1, 32'd101, 5'd6})
      $display("FAIL after_flush got v=%b r=%0d rd=%0d exp v=1 r=101 rd=6",
               bus.out_valid, bus.out_result, bus.out_rd);
    else pass_cnt++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    total_cnt++;
    if ({bus.out_valid, bus.out_result, bus.out_store_data, bus.out_rd, bus.out_reg_write,
         bus.out_mem_read, bus.out_mem_write, bus.out_zero, bus.out_ovf_trap,
         bus.out_illegal, bus.in_ready} !== {76'd0, 1'b1})
      $display("FAIL rst_mid_stall got v=%b r=%h rd=%0d rw=%b ir=%b exp all 0 ir=1",
               bus.out_valid, bus.out_result, bus.out_rd, bus.out_reg_write, bus.in_ready);
    else pass_cnt++;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b0;
    clear_fwd();
    test_reset();
    test_alu_ops();
    test_forwarding();
    test_overflow();
    test_immediate();
    test_illegal();
    test_back_to_back();
    test_stall_flush();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
